// File: rtl/arbiter_game_timers.sv
// Timer/LED responder for the arbiter-game control FSM: shared tick prescaler,
// countdown timer, win-hold timer and registered LED driver (bar or winner blink).
module arbiter_game_timers #(
    parameter int PRESCALE = 12_000_000,
    parameter int CD_STEPS = 4,
    parameter int W_TICKS  = 3,
    parameter int N_LEDS   = 4
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              cd_rst,
    input  logic              w_rst,
    input  logic              leds_rst,
    input  logic              leds_sel,
    input  logic              gnt1,
    input  logic              gnt2,
    output logic              cd_done_out,
    output logic              w_done_out,
    output logic [N_LEDS-1:0] leds_out
);

    localparam int TW   = $clog2(PRESCALE);
    localparam int CW   = $clog2(CD_STEPS + 1);
    localparam int WW   = $clog2(W_TICKS + 1);
    localparam int HALF = N_LEDS / 2;

    logic [TW-1:0]     tick_cnt, tick_cnt_next;
    logic [CW-1:0]     cd_cnt, cd_cnt_next;
    logic [WW-1:0]     w_cnt, w_cnt_next;
    logic              phase, phase_next;
    logic [N_LEDS-1:0] leds_next;
    logic              run;
    logic              tick;
    logic [31:0]       cd_ext;

    // Prescaler only runs while at least one timer is active, so each timer
    // starts from a fresh tick boundary when released.
    always_comb begin
        run  = ~(cd_rst & w_rst);
        tick = run && (tick_cnt == TW'(PRESCALE - 1));

        tick_cnt_next = tick_cnt;
        if (!run || tick) begin
            tick_cnt_next = '0;
        end else begin
            tick_cnt_next = tick_cnt + TW'(1);
        end

        cd_cnt_next = cd_cnt;
        if (cd_rst) begin
            cd_cnt_next = CW'(CD_STEPS);
        end else if (tick && (cd_cnt != '0)) begin
            cd_cnt_next = cd_cnt - CW'(1);
        end

        w_cnt_next = w_cnt;
        if (w_rst) begin
            w_cnt_next = '0;
        end else if (tick && (w_cnt != WW'(W_TICKS))) begin
            w_cnt_next = w_cnt + WW'(1);
        end

        phase_next = phase;
        if (!leds_sel || leds_rst) begin
            phase_next = 1'b0;
        end else if (tick) begin
            phase_next = ~phase;
        end
    end

    // LEDs are decoded from the next-state values so the pattern changes on
    // the same edge as the counter it reflects.
    always_comb begin
        leds_next = '0;
        cd_ext    = 32'(cd_cnt_next);
        if (leds_rst) begin
            leds_next = '0;
        end else if (!leds_sel) begin
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                leds_next[i] = (i < cd_ext);
            end
        end else if (gnt1 && !gnt2) begin
            leds_next[N_LEDS-1:HALF] = {HALF{~phase_next}};
        end else if (gnt2 && !gnt1) begin
            leds_next[HALF-1:0] = {HALF{~phase_next}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            tick_cnt <= '0;
            cd_cnt   <= CW'(CD_STEPS);
            w_cnt    <= '0;
            phase    <= 1'b0;
            leds_out <= '0;
        end else begin
            tick_cnt <= tick_cnt_next;
            cd_cnt   <= cd_cnt_next;
            w_cnt    <= w_cnt_next;
            phase    <= phase_next;
            leds_out <= leds_next;
        end
    end

    assign cd_done_out = (cd_cnt == '0);
    assign w_done_out  = (w_cnt == WW'(W_TICKS));

endmodule

// File: tb/tb_arbiter_game_timers.sv
// Directed bench for arbiter_game_timers with PRESCALE=4, CD_STEPS=3, W_TICKS=2, N_LEDS=4.
module tb_arbiter_game_timers;

    logic       clk = 1'b0;
    logic       rst_in, cd_rst, w_rst, leds_rst, leds_sel, gnt1, gnt2;
    logic       cd_done_out, w_done_out;
    logic [3:0] leds_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] therm_tbl [0:3] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};

    arbiter_game_timers #(
        .PRESCALE(4), .CD_STEPS(3), .W_TICKS(2), .N_LEDS(4)
    ) dut (
        .clk(clk), .rst_in(rst_in), .cd_rst(cd_rst), .w_rst(w_rst),
        .leds_rst(leds_rst), .leds_sel(leds_sel), .gnt1(gnt1), .gnt2(gnt2),
        .cd_done_out(cd_done_out), .w_done_out(w_done_out), .leds_out(leds_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cd_exp;
        int ph;

        rst_in = 1'b1; cd_rst = 1'b0; w_rst = 1'b0; leds_rst = 1'b0;
        leds_sel = 1'b0; gnt1 = 1'b0; gnt2 = 1'b0;

        // 1: reset holds everything dark regardless of inputs
        for (int i = 0; i < 5; i++) begin
            cd_rst   = 1'($urandom_range(0, 1));
            w_rst    = 1'($urandom_range(0, 1));
            leds_rst = 1'($urandom_range(0, 1));
            leds_sel = 1'($urandom_range(0, 1));
            gnt1     = 1'($urandom_range(0, 1));
            gnt2     = 1'($urandom_range(0, 1));
            step();
            check("rst_leds", 32'(leds_out), 32'h0);
            check("rst_cd_done", 32'(cd_done_out), 32'h0);
            check("rst_w_done", 32'(w_done_out), 32'h0);
        end

        // 2: full countdown
        rst_in = 1'b0; cd_rst = 1'b1; w_rst = 1'b1; leds_rst = 1'b0;
        leds_sel = 1'b0; gnt1 = 1'b0; gnt2 = 1'b0;
        step();
        check("cd_loaded_leds", 32'(leds_out), 32'h7);
        check("cd_loaded_done", 32'(cd_done_out), 32'h0);
        cd_rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            cd_exp = 3 - e / 4;
            check("cd_run_leds", 32'(leds_out), 32'(therm_tbl[cd_exp]));
            check("cd_run_done", 32'(cd_done_out), 32'(cd_exp == 0));
        end
        for (int i = 0; i < 20; i++) begin
            step();
            check("cd_hold_done", 32'(cd_done_out), 32'h1);
            check("cd_hold_leds", 32'(leds_out), 32'h0);
        end
        cd_rst = 1'b1;
        step();
        check("cd_reload_done", 32'(cd_done_out), 32'h0);
        check("cd_reload_leds", 32'(leds_out), 32'h7);

        // 3: reload pulse mid-countdown restarts a full tick
        cd_rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("cd_pre_leds", 32'(leds_out), 32'(therm_tbl[3 - e / 4]));
        end
        cd_rst = 1'b1;
        step();
        check("cd_pulse_leds", 32'(leds_out), 32'h7);
        check("cd_pulse_done", 32'(cd_done_out), 32'h0);
        cd_rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check("cd_post_leds", 32'(leds_out), (e == 4) ? 32'h3 : 32'h7);
        end

        // 4: player 1 wins, blink upper half, win-hold expires
        cd_rst = 1'b1; w_rst = 1'b1; leds_sel = 1'b0;
        step();
        w_rst = 1'b0; leds_sel = 1'b1; gnt1 = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            ph = (e / 4) % 2;
            check("w1_leds", 32'(leds_out), (ph != 0) ? 32'h0 : 32'hC);
            check("w1_done", 32'(w_done_out), 32'(e >= 8));
        end
        w_rst = 1'b1;
        step();
        check("w1_clear_done", 32'(w_done_out), 32'h0);

        // 5: player 2 wins, then illegal grant and LED blanking
        leds_sel = 1'b0; gnt1 = 1'b0;
        step();
        w_rst = 1'b0; leds_sel = 1'b1; gnt2 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            ph = (e / 4) % 2;
            check("w2_leds", 32'(leds_out), (ph != 0) ? 32'h0 : 32'h3);
        end
        gnt1 = 1'b1;
        step();
        check("both_gnt_leds", 32'(leds_out), 32'h0);
        gnt1 = 1'b0;
        step();
        check("gnt2_again_leds", 32'(leds_out), 32'h3);
        leds_rst = 1'b1;
        step();
        check("leds_rst_leds", 32'(leds_out), 32'h0);

        // 6: reset mid-countdown
        leds_rst = 1'b0; leds_sel = 1'b0; gnt2 = 1'b0; cd_rst = 1'b1; w_rst = 1'b1;
        step();
        cd_rst = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        check("mid_cd_leds", 32'(leds_out), 32'h3);
        rst_in = 1'b1;
        step();
        check("mid_cd_rst_leds", 32'(leds_out), 32'h0);
        check("mid_cd_rst_done", 32'(cd_done_out), 32'h0);
        check("mid_cd_rst_wdone", 32'(w_done_out), 32'h0);
        rst_in = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check("after_rst_cd_leds", 32'(leds_out), (e == 4) ? 32'h3 : 32'h7);
        end

        // 6b: reset mid-win-hold
        cd_rst = 1'b1; w_rst = 1'b0; leds_sel = 1'b1; gnt1 = 1'b1;
        for (int e = 1; e <= 9; e++) step();
        check("mid_w_done", 32'(w_done_out), 32'h1);
        check("mid_w_leds", 32'(leds_out), 32'hC);
        rst_in = 1'b1;
        step();
        check("mid_w_rst_leds", 32'(leds_out), 32'h0);
        check("mid_w_rst_wdone", 32'(w_done_out), 32'h0);
        check("mid_w_rst_cddone", 32'(cd_done_out), 32'h0);
        rst_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            ph = (e / 4) % 2;
            check("after_rst_w_leds", 32'(leds_out), (ph != 0) ? 32'h0 : 32'hC);
            check("after_rst_w_done", 32'(w_done_out), 32'(e >= 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
